// File: rtl/dram_responder_pkg.sv
// Shared types and constants for the DRAM responder and its latency counter.
package dram_responder_pkg;

    localparam int unsigned DRAM_ADDR_W = 27;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CTR_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Any set bit above the word index means the access lies outside the array.
    function automatic logic addr_oor(input logic [DRAM_ADDR_W-1:0] addr,
                                      input int unsigned aw);
        return (addr >> (aw + 2)) != '0;
    endfunction

endpackage

// File: rtl/dram_resp_lat_ctr.sv
// Latency down-counter: loaded on acceptance, decremented while waiting, done at 1.
module dram_resp_lat_ctr
    import dram_responder_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    input  logic             dec,
    output logic [CTR_W-1:0] value,
    output logic             done_c
);

    logic [CTR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value  = cnt_q;
    assign done_c = (cnt_q == CTR_W'(1));

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder for the valid/ready DRAM request bus, backed by a word array.
// Define DRAM_RESP_ROW_HIT_EN to give requests hitting the last accessed row HIT_LAT latency.
module dram_responder
    import dram_responder_pkg::*;
#(
    parameter int unsigned AW      = 14,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned HIT_LAT = 2,
    parameter int unsigned ROW_LSB = 12
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   valid_dram,
    input  logic                   rw_dram,
    input  logic [DRAM_ADDR_W-1:0] addr_dram,
    input  logic [DATA_W-1:0]      din_dram,
    output logic                   ready_dram,
    output logic [DATA_W-1:0]      dout_dram,
    output logic                   busy,
    output logic                   err_oor
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              rw_q, rw_d;
    logic              oor_q, oor_d;

    logic [AW-1:0]     idx_in_c;
    logic              oor_in_c;
    logic              accept_c;
    logic [CTR_W-1:0]  lat_sel_c;
    logic [AW-1:0]     rd_idx_c;
    logic              rd_oor_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              mem_we_c;

    logic              ctr_load_c;
    logic              ctr_dec_c;
    logic [CTR_W-1:0]  ctr_value;
    logic              ctr_done_c;

    assign idx_in_c = addr_dram[AW+1:2];
    assign oor_in_c = addr_oor(addr_dram, AW);
    assign accept_c = (state_q == ST_IDLE) && valid_dram;

`ifdef DRAM_RESP_ROW_HIT_EN
    localparam int unsigned ROW_W = DRAM_ADDR_W - ROW_LSB;

    logic [ROW_W-1:0] row_q, row_d;
    logic             row_vld_q, row_vld_d;
    logic             row_hit_c;

    assign row_hit_c = row_vld_q && (row_q == addr_dram[DRAM_ADDR_W-1:ROW_LSB]);
    assign lat_sel_c = row_hit_c ? CTR_W'(HIT_LAT) : CTR_W'(LATENCY);

    always_comb begin
        row_d     = row_q;
        row_vld_d = row_vld_q;
        if (accept_c) begin
            row_d     = addr_dram[DRAM_ADDR_W-1:ROW_LSB];
            row_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            row_q     <= '0;
            row_vld_q <= 1'b0;
        end else begin
            row_q     <= row_d;
            row_vld_q <= row_vld_d;
        end
    end
`else
    localparam int unsigned unused_cfg = HIT_LAT + ROW_LSB;

    assign lat_sel_c = CTR_W'(LATENCY);
`endif

    // A latency-1 read is served straight from the live bus; otherwise from the captured copy.
    assign rd_idx_c  = (state_q == ST_IDLE) ? idx_in_c : idx_q;
    assign rd_oor_c  = (state_q == ST_IDLE) ? oor_in_c : oor_q;
    assign rd_data_c = rd_oor_c ? '0 : mem[rd_idx_c];
    assign mem_we_c  = rstn && accept_c && rw_dram && !oor_in_c;

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx_in_c] <= din_dram;
        end
    end

    dram_resp_lat_ctr u_lat_ctr (
        .clk      (clk),
        .rstn     (rstn),
        .load     (ctr_load_c),
        .load_val (lat_sel_c - CTR_W'(1)),
        .dec      (ctr_dec_c),
        .value    (ctr_value),
        .done_c   (ctr_done_c)
    );

    always_comb begin
        state_d    = state_q;
        ready_d    = 1'b0;
        busy_d     = busy_q;
        err_d      = err_q;
        dout_d     = dout_q;
        idx_d      = idx_q;
        rw_d       = rw_q;
        oor_d      = oor_q;
        ctr_load_c = 1'b0;
        ctr_dec_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (valid_dram) begin
                    idx_d  = idx_in_c;
                    rw_d   = rw_dram;
                    oor_d  = oor_in_c;
                    err_d  = err_q | oor_in_c;
                    busy_d = 1'b1;
                    if (lat_sel_c == CTR_W'(1)) begin
                        state_d = ST_RESP;
                        ready_d = 1'b1;
                        if (!rw_dram) begin
                            dout_d = rd_data_c;
                        end
                    end else begin
                        state_d    = ST_WAIT;
                        ctr_load_c = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                ctr_dec_c = 1'b1;
                if (ctr_done_c) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    if (!rw_q) begin
                        dout_d = rd_data_c;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            oor_q   <= oor_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{addr_dram[1:0], ctr_value};

    assign ready_dram = ready_q;
    assign dout_dram  = dout_q;
    assign busy       = busy_q;
    assign err_oor    = err_q;

endmodule
